// File: rtl/kalman_fp_pkg.sv
// Shared fixed-point definitions for the Kalman datapath: Q/N defaults,
// the fixed-point ONE constant, saturation limits and a clog2 helper.
package kalman_fp_pkg;

  localparam int unsigned Q_DEF = 18;
  localparam int unsigned N_DEF = 32;

  // Saturation limits for the default word width
  localparam logic [N_DEF-1:0] MAXPOS = {1'b0, {(N_DEF-1){1'b1}}};
  localparam logic [N_DEF-1:0] MAXNEG = {1'b1, {(N_DEF-1){1'b0}}};

  // Fixed-point 1.0 for a given fraction width
  function automatic logic [63:0] fp_one(input int unsigned q);
    return 64'd1 << q;
  endfunction

  // Largest positive value of an n-bit signed word (low n bits significant)
  function automatic logic [63:0] sat_maxpos(input int unsigned n);
    return (64'd1 << (n - 1)) - 64'd1;
  endfunction

  // Most negative value of an n-bit signed word (low n bits significant)
  function automatic logic [63:0] sat_maxneg(input int unsigned n);
    return 64'd1 << (n - 1);
  endfunction

  // Number of bits needed to index v items
  function automatic int unsigned clog2(input int unsigned v);
    int unsigned r;
    r = 0;
    while ((32'd1 << r) < v) r = r + 1;
    return r;
  endfunction

endpackage

// File: rtl/qmult.sv
// Combinational signed Q-format multiplier: returns bits [N-1+Q:Q] of the
// 2N-bit product and flags when the scaled product does not fit in N bits.
module qmult #(
  parameter int unsigned Q = 18,
  parameter int unsigned N = 32
) (
  input  logic [N-1:0] a,
  input  logic [N-1:0] b,
  output logic [N-1:0] result,
  output logic         overflow
);

  logic signed [2*N-1:0] a_ext;
  logic signed [2*N-1:0] b_ext;
  logic signed [2*N-1:0] product;
  logic signed [2*N-1:0] scaled;
  logic        [N:0]     upper;

  // Full-precision product, rescaled; overflow when the bits above the
  // result slice are not a pure sign extension of it
  always_comb begin
    a_ext    = {{N{a[N-1]}}, a};
    b_ext    = {{N{b[N-1]}}, b};
    product  = a_ext * b_ext;
    scaled   = product >>> Q;
    result   = scaled[N-1:0];
    upper    = scaled[2*N-1:N-1];
    overflow = (upper != '0) && (upper != '1);
  end

endmodule

// File: rtl/rr_arbiter.sv
// Round-robin grant: first requester found searching upward from ptr,
// wrapping at NREQ. Grant is one-hot or zero and is suppressed when !en.
module rr_arbiter #(
  parameter int unsigned NREQ = 4,
  parameter int unsigned IDW  = 2
) (
  input  logic [NREQ-1:0] req,
  input  logic [IDW-1:0]  ptr,
  input  logic            en,
  output logic [NREQ-1:0] grant,
  output logic [IDW-1:0]  idx
);

  logic              found;
  logic [NREQ-1:0]   rot;
  int unsigned       j;

  // Priority search from the pointer, modulo NREQ
  always_comb begin
    found = 1'b0;
    idx   = '0;
    rot   = '0;
    j     = 0;
    for (int unsigned k = 0; k < NREQ; k++) begin
      j = 32'(ptr) + k;
      if (j >= NREQ) j = j - NREQ;
      rot = req >> j;
      if (!found && rot[0]) begin
        found = 1'b1;
        idx   = j[IDW-1:0];
      end
    end
    grant = (en && found) ? (NREQ'(1) << idx) : '0;
  end

endmodule

// File: rtl/qmult_arbiter.sv
// Shares one qmult among NREQ requesters: round-robin valid/ready intake,
// operand stage (S1), registered tagged result with overflow and sticky
// per-requester overflow flags. Optional macro QMULT_ARB_SAT_EN clamps
// overflowing results to the signed limits instead of wrapping.
module qmult_arbiter
  import kalman_fp_pkg::*;
#(
  parameter int unsigned Q    = Q_DEF,
  parameter int unsigned N    = N_DEF,
  parameter int unsigned NREQ = 4,
  parameter int unsigned IDW  = clog2(NREQ)
) (
  input  logic              clk,
  input  logic              rst,
  input  logic [NREQ-1:0]   req_valid,
  output logic [NREQ-1:0]   req_ready,
  input  logic [NREQ*N-1:0] req_a,
  input  logic [NREQ*N-1:0] req_b,
  output logic              rsp_valid,
  input  logic              rsp_ready,
  output logic [IDW-1:0]    rsp_id,
  output logic [N-1:0]      rsp_data,
  output logic              rsp_ovr,
  output logic [NREQ-1:0]   ovr_sticky,
  input  logic [NREQ-1:0]   ovr_clr
);

  logic              en;
  logic [NREQ-1:0]   grant;
  logic [IDW-1:0]    grant_idx;
  logic [IDW-1:0]    rr_ptr;
  logic [N-1:0]      sel_a;
  logic [N-1:0]      sel_b;

  logic              s1_valid;
  logic [N-1:0]      s1_a;
  logic [N-1:0]      s1_b;
  logic [IDW-1:0]    s1_id;

  logic [N-1:0]      mul_result;
  logic [N-1:0]      mul_data;
  logic              mul_ovr;
  logic [NREQ-1:0]   sticky_set;

  // Whole pipeline advances together unless a held result is refused
  always_comb en = !rsp_valid || rsp_ready;

  // Grant is held off during reset so no handshake can be lost to it
  rr_arbiter #(
    .NREQ (NREQ),
    .IDW  (IDW)
  ) u_rr_arbiter (
    .req   (req_valid),
    .ptr   (rr_ptr),
    .en    (en && !rst),
    .grant (grant),
    .idx   (grant_idx)
  );

  assign req_ready = grant;

  // Operand select for the granted requester
  always_comb begin
    sel_a = N'(req_a >> (32'(grant_idx) * N));
    sel_b = N'(req_b >> (32'(grant_idx) * N));
  end

  // Pointer moves past the winner; a refused requester keeps its priority
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      rr_ptr <= '0;
    end else if (grant != '0) begin
      rr_ptr <= (32'(grant_idx) == NREQ - 1) ? '0 : grant_idx + 1'b1;
    end
  end

  // Operand stage; a cycle without a grant inserts a bubble
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      s1_valid <= 1'b0;
      s1_a     <= '0;
      s1_b     <= '0;
      s1_id    <= '0;
    end else if (en) begin
      s1_valid <= (grant != '0);
      if (grant != '0) begin
        s1_a  <= sel_a;
        s1_b  <= sel_b;
        s1_id <= grant_idx;
      end
    end
  end

  qmult #(
    .Q (Q),
    .N (N)
  ) u_qmult (
    .a        (s1_a),
    .b        (s1_b),
    .result   (mul_result),
    .overflow (mul_ovr)
  );

`ifdef QMULT_ARB_SAT_EN
  localparam logic [N-1:0] SAT_POS = N'(sat_maxpos(N));
  localparam logic [N-1:0] SAT_NEG = N'(sat_maxneg(N));

  // Clamp toward the sign the exact product would have had
  always_comb begin
    mul_data = mul_result;
    if (mul_ovr) mul_data = (s1_a[N-1] ^ s1_b[N-1]) ? SAT_NEG : SAT_POS;
  end
`else
  // Overflowing products are returned as the wrapped slice
  always_comb mul_data = mul_result;
`endif

  // Output register; payload only reloads when S1 carries a product
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      rsp_valid <= 1'b0;
      rsp_id    <= '0;
      rsp_data  <= '0;
      rsp_ovr   <= 1'b0;
    end else if (en) begin
      rsp_valid <= s1_valid;
      if (s1_valid) begin
        rsp_id   <= s1_id;
        rsp_data <= mul_data;
        rsp_ovr  <= mul_ovr;
      end
    end
  end

  // Overflow of an accepted result flags its requester
  always_comb begin
    sticky_set = '0;
    if (rsp_valid && rsp_ready && rsp_ovr) sticky_set = NREQ'(1) << rsp_id;
  end

  // Sticky flags; a set in the same cycle as a clear wins
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      ovr_sticky <= '0;
    end else begin
      ovr_sticky <= (ovr_sticky & ~ovr_clr) | sticky_set;
    end
  end

endmodule

// File: tb/tb_qmult_arbiter.sv
// Self-checking bench for qmult_arbiter: reset values, a vector table,
// hand-written multi-cycle sequences and a randomized run against a
// behavioural model (exact integer arithmetic plus a two-slot queue).
`timescale 1ns/1ps
module tb_qmult_arbiter;
  import kalman_fp_pkg::*;

  localparam int unsigned Q    = 18;
  localparam int unsigned N    = 32;
  localparam int unsigned NREQ = 4;
  localparam int unsigned IDW  = 2;

  logic              clk = 1'b0;
  logic              rst;
  logic [NREQ-1:0]   req_valid;
  logic [NREQ-1:0]   req_ready;
  logic [NREQ*N-1:0] req_a;
  logic [NREQ*N-1:0] req_b;
  logic              rsp_valid;
  logic              rsp_ready;
  logic [IDW-1:0]    rsp_id;
  logic [N-1:0]      rsp_data;
  logic              rsp_ovr;
  logic [NREQ-1:0]   ovr_sticky;
  logic [NREQ-1:0]   ovr_clr;

  qmult_arbiter #(.Q(Q), .N(N), .NREQ(NREQ), .IDW(IDW)) dut (
    .clk        (clk),
    .rst        (rst),
    .req_valid  (req_valid),
    .req_ready  (req_ready),
    .req_a      (req_a),
    .req_b      (req_b),
    .rsp_valid  (rsp_valid),
    .rsp_ready  (rsp_ready),
    .rsp_id     (rsp_id),
    .rsp_data   (rsp_data),
    .rsp_ovr    (rsp_ovr),
    .ovr_sticky (ovr_sticky),
    .ovr_clr    (ovr_clr)
  );

  always #5 clk = ~clk;

  int errors = 0;
  int checks = 0;
  int cyc    = 0;

  // Requester side: pending operand per requester
  bit           rq_v [NREQ];
  logic [N-1:0] rq_a [NREQ];
  logic [N-1:0] rq_b [NREQ];

  // Reference model: rr pointer, in-flight queue (front = response slot)
  typedef struct { bit v; int id; logic [N-1:0] a; logic [N-1:0] b; } item_t;
  item_t           pipe[$];
  int              m_ptr;
  logic [NREQ-1:0] m_sticky;

  // Observations of the DUT
  int grant_log[$];
  int rsp_id_log[$];
  int rsp_cyc_log[$];
  int hs_count;
  int acc_count;

  typedef struct {
    int           id;
    logic [N-1:0] a;
    logic [N-1:0] b;
    logic [N-1:0] exp_wrap;
    logic [N-1:0] exp_sat;
    bit           exp_ovr;
  } vec_t;
  vec_t vt[11];

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  // Exact product by integer arithmetic, scaled back by 2^Q
  function automatic void ref_mul(input logic [N-1:0] a, input logic [N-1:0] b,
                                  output logic [N-1:0] r, output bit ovr);
    longint p, s, lim;
    p   = longint'($signed(a)) * longint'($signed(b));
    s   = p >>> Q;
    lim = longint'(1) << (N - 1);
    ovr = (s >= lim) || (s < -lim);
    r   = N'(s);
`ifdef QMULT_ARB_SAT_EN
    if (ovr) r = (a[N-1] ^ b[N-1]) ? {1'b1, {(N-1){1'b0}}} : {1'b0, {(N-1){1'b1}}};
`endif
  endfunction

  function automatic logic [N-1:0] rand_op();
    logic [31:0] r;
    case ($urandom_range(0, 3))
      0:       r = $urandom;
      1:       r = $urandom_range(0, 32'h00FF_FFFF) - 32'h0080_0000;
      2:       r = 32'h4000_0000 >> $urandom_range(0, 14);
      default: r = {($urandom_range(0, 1) != 0) ? 12'hFFF : 12'h000, 20'($urandom)};
    endcase
    return r;
  endfunction

  function automatic bit model_idle();
    bit idle;
    idle = !pipe[0].v && !pipe[1].v;
    for (int i = 0; i < NREQ; i++) if (rq_v[i]) idle = 0;
    return idle;
  endfunction

  task automatic drive();
    for (int i = 0; i < NREQ; i++) begin
      req_valid[i]       = rq_v[i];
      req_a[i*N +: N]    = rq_a[i];
      req_b[i*N +: N]    = rq_b[i];
    end
  endtask

  task automatic model_reset();
    item_t bub;
    bub = '{v: 0, id: 0, a: '0, b: '0};
    pipe.delete();
    pipe.push_back(bub);
    pipe.push_back(bub);
    m_ptr    = 0;
    m_sticky = '0;
  endtask

  // One clock cycle: called at the falling edge, applies inputs, checks the
  // DUT against the model, advances the model, returns at the next falling edge
  task automatic tick(input logic rdy, input logic [NREQ-1:0] clr, input logic [NREQ-1:0] refill);
    int              g, gi, j;
    bit              en, eo;
    logic [NREQ-1:0] exp_ready, setb;
    logic [N-1:0]    ed;
    item_t           nxt;
    for (int i = 0; i < NREQ; i++)
      if (refill[i] && !rq_v[i]) begin
        rq_v[i] = 1;
        rq_a[i] = rand_op();
        rq_b[i] = rand_op();
      end
    drive();
    rsp_ready = rdy;
    ovr_clr   = clr;
    #1;
    en = !pipe[0].v || rdy;
    g  = -1;
    if (en)
      for (int k = 0; k < NREQ; k++) begin
        j = (m_ptr + k) % NREQ;
        if (g < 0 && rq_v[j]) g = j;
      end
    exp_ready = (g >= 0) ? (NREQ'(1) << g) : '0;
    chk("req_ready", req_ready, exp_ready);
    chk("rsp_valid", rsp_valid, pipe[0].v);
    eo = 0;
    if (pipe[0].v) begin
      ref_mul(pipe[0].a, pipe[0].b, ed, eo);
      chk("rsp_id", rsp_id, pipe[0].id);
      chk("rsp_data", rsp_data, ed);
      chk("rsp_ovr", rsp_ovr, eo);
    end
    chk("ovr_sticky", ovr_sticky, m_sticky);
    if ((req_ready & req_valid) != '0) begin
      gi = -1;
      for (int i = 0; i < NREQ; i++) if (req_ready[i]) gi = i;
      grant_log.push_back(gi);
      hs_count++;
    end
    if (rsp_valid && rdy) begin
      rsp_id_log.push_back(int'(rsp_id));
      rsp_cyc_log.push_back(cyc);
      acc_count++;
    end
    setb = '0;
    if (pipe[0].v && rdy && eo) setb = NREQ'(1) << pipe[0].id;
    m_sticky = (m_sticky & ~clr) | setb;
    if (en) begin
      nxt = '{v: 0, id: 0, a: '0, b: '0};
      if (g >= 0) begin
        nxt   = '{v: 1, id: g, a: rq_a[g], b: rq_b[g]};
        m_ptr = (g + 1) % NREQ;
        rq_v[g] = 0;
      end
      void'(pipe.pop_front());
      pipe.push_back(nxt);
    end
    @(posedge clk);
    cyc++;
    @(negedge clk);
  endtask

  task automatic drain(input string name);
    for (int k = 0; k < 40 && !model_idle(); k++) tick(1'b1, '0, '0);
    if (!model_idle()) begin
      errors++;
      $display("FAIL %s: pipeline not drained within 40 cycles", name);
    end
    chk(name, rsp_valid, 1'b0);
  endtask

  task automatic present(input int id, input logic [N-1:0] a, input logic [N-1:0] b);
    rq_v[id] = 1;
    rq_a[id] = a;
    rq_b[id] = b;
  endtask

  initial begin
    logic [N-1:0] cap_data, ed;
    logic [IDW-1:0] cap_id;
    bit eo;
    int exp_order[8] = '{0, 1, 2, 3, 0, 1, 2, 3};

    vt[0]  = '{0, 32'h0006_0000, 32'hFFF8_0000, 32'hFFF4_0000, 32'hFFF4_0000, 0};
    vt[1]  = '{1, 32'h0004_0000, 32'h0004_0000, 32'h0004_0000, 32'h0004_0000, 0};
    vt[2]  = '{3, 32'h0000_0000, 32'h1234_5678, 32'h0000_0000, 32'h0000_0000, 0};
    vt[3]  = '{2, 32'hFFFC_0000, 32'hFFFC_0000, 32'h0004_0000, 32'h0004_0000, 0};
    vt[4]  = '{2, 32'h4000_0000, 32'h4000_0000, 32'h0000_0000, 32'h7FFF_FFFF, 1};
    vt[5]  = '{1, 32'h4000_0000, 32'hC000_0000, 32'h0000_0000, 32'h8000_0000, 1};
    vt[6]  = '{0, 32'h0000_0001, 32'h0000_0001, 32'h0000_0000, 32'h0000_0000, 0};
    vt[7]  = '{3, 32'h0002_0000, 32'hFFFE_0000, 32'hFFFF_0000, 32'hFFFF_0000, 0};
    vt[8]  = '{0, 32'h7FFF_FFFF, 32'h0004_0000, 32'h7FFF_FFFF, 32'h7FFF_FFFF, 0};
    vt[9]  = '{1, 32'h8000_0000, 32'h0004_0000, 32'h8000_0000, 32'h8000_0000, 0};
    vt[10] = '{3, 32'h8000_0000, 32'hFFFC_0000, 32'h8000_0000, 32'h7FFF_FFFF, 1};

    // Reset values
    rst = 1'b1;
    for (int i = 0; i < NREQ; i++) begin rq_v[i] = 0; rq_a[i] = '0; rq_b[i] = '0; end
    drive();
    rsp_ready = 1'b0;
    ovr_clr   = '0;
    repeat (2) @(negedge clk);
    chk("rst_req_ready", req_ready, '0);
    chk("rst_rsp_valid", rsp_valid, 1'b0);
    chk("rst_rsp_id", rsp_id, '0);
    chk("rst_rsp_data", rsp_data, '0);
    chk("rst_rsp_ovr", rsp_ovr, 1'b0);
    chk("rst_ovr_sticky", ovr_sticky, '0);
    rst = 1'b0;
    model_reset();

    // All four requesters contend: strict rotation, back-to-back results
    grant_log.delete(); rsp_id_log.delete(); rsp_cyc_log.delete();
    for (int k = 1; k <= 8; k++)
      tick(1'b1, '0, (k == 1) ? '1 : ((k <= 5) ? (NREQ'(1) << (k - 2)) : '0));
    drain("rr_drain");
    for (int i = 0; i < 8; i++) begin
      chk($sformatf("rr_grant%0d", i), (grant_log.size() > i) ? grant_log[i] : -1, exp_order[i]);
      chk($sformatf("rr_rsp%0d", i), (rsp_id_log.size() > i) ? rsp_id_log[i] : -1, exp_order[i]);
    end
    chk("rr_back2back", (rsp_cyc_log.size() == 8) ? rsp_cyc_log[7] - rsp_cyc_log[0] : -1, 7);

    // Vector table: one product at a time, result two cycles after handshake
    for (int i = 0; i < 11; i++) begin
      present(vt[i].id, vt[i].a, vt[i].b);
      tick(1'b1, '0, '0);
      tick(1'b1, '0, '0);
      chk($sformatf("vec%0d_valid", i), rsp_valid, 1'b1);
      chk($sformatf("vec%0d_id", i), rsp_id, vt[i].id);
`ifdef QMULT_ARB_SAT_EN
      chk($sformatf("vec%0d_data", i), rsp_data, vt[i].exp_sat);
`else
      chk($sformatf("vec%0d_data", i), rsp_data, vt[i].exp_wrap);
`endif
      chk($sformatf("vec%0d_ovr", i), rsp_ovr, vt[i].exp_ovr);
      tick(1'b1, '0, '0);
    end

    // Backpressure: everything holds, nothing lost or duplicated
    hs_count = 0; acc_count = 0;
    tick(1'b1, '0, '1);
    tick(1'b1, '0, '1);
    cap_id   = rsp_id;
    cap_data = rsp_data;
    for (int k = 0; k < 5; k++) begin
      tick(1'b0, '0, '1);
      chk("stall_ready", req_ready, '0);
      chk("stall_valid", rsp_valid, 1'b1);
      chk("stall_id", rsp_id, cap_id);
      chk("stall_data", rsp_data, cap_data);
    end
    drain("stall_drain");
    chk("stall_count", acc_count, hs_count);

    // Sticky overflow for requester 2, held until cleared
    tick(1'b1, '1, '0);
    chk("sticky_cleared", ovr_sticky, '0);
    present(2, 32'h4000_0000, 32'h4000_0000);
    tick(1'b1, '0, '0);
    tick(1'b1, '0, '0);
    chk("ovf_rsp_ovr", rsp_ovr, 1'b1);
    chk("ovf_sticky_early", ovr_sticky[2], 1'b0);
    tick(1'b1, '0, '0);
    chk("ovf_sticky_set", ovr_sticky[2], 1'b1);
    repeat (3) tick(1'b1, '0, '0);
    chk("ovf_sticky_hold", ovr_sticky[2], 1'b1);
    tick(1'b1, 4'b0100, '0);
    chk("ovf_sticky_clr", ovr_sticky[2], 1'b0);

    // Clear and set on the same cycle for requester 1: set wins
    present(1, 32'h4000_0000, 32'hC000_0000);
    tick(1'b1, '0, '0);
    tick(1'b1, '0, '0);
    chk("setclr_before", ovr_sticky[1], 1'b0);
    tick(1'b1, 4'b0010, '0);
    chk("setclr_wins", ovr_sticky[1], 1'b1);

    // Randomized traffic against the model
    hs_count = 0; acc_count = 0;
    for (int k = 0; k < 400; k++)
      tick($urandom_range(0, 3) != 0,
           ($urandom_range(0, 15) == 0) ? NREQ'($urandom) : '0,
           NREQ'($urandom));
    drain("rand_drain");
    chk("rand_count", acc_count, hs_count);

    // Reset with two products in flight
    present(3, 32'h4000_0000, 32'h4000_0000);
    repeat (3) tick(1'b1, '0, '0);
    present(0, 32'h0004_0000, 32'h0008_0000);
    present(1, 32'h0004_0000, 32'h000C_0000);
    tick(1'b1, '0, '0);
    present(2, 32'h0004_0000, 32'h0010_0000);
    tick(1'b1, '0, '0);
    chk("prerst_valid", rsp_valid, 1'b1);
    chk("prerst_sticky", ovr_sticky[3], 1'b1);
    #2 rst = 1'b1;
    #1;
    chk("midrst_valid", rsp_valid, 1'b0);
    chk("midrst_sticky", ovr_sticky, '0);
    chk("midrst_ready", req_ready, '0);
    for (int i = 0; i < NREQ; i++) rq_v[i] = 0;
    drive();
    model_reset();
    @(posedge clk);
    @(negedge clk);
    rst = 1'b0;
    for (int k = 0; k < 3; k++) begin
      tick(1'b1, '0, '0);
      chk("postrst_quiet", rsp_valid, 1'b0);
    end
    grant_log.delete();
    present(1, 32'h0004_0000, 32'h0004_0000);
    present(3, 32'h0004_0000, 32'h0004_0000);
    tick(1'b1, '0, '0);
    chk("postrst_ptr", (grant_log.size() > 0) ? grant_log[0] : -1, 1);
    drain("postrst_drain");

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
